// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and state types for the GMII preamble/SFD
// transmit and receive blocks.
package eth_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA     = 3'd2,
        IFG      = 3'd3
    } tx_state_t;

endpackage

// File: rtl/preamble_sfd_tx.sv
// GMII transmit framer: prepends preamble and SFD to a MAC byte stream,
// enforces the inter-frame gap and signals upstream underrun on TX_ER.
module preamble_sfd_tx
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12
) (
    input  logic       mac_gmii_tx_clk,
    input  logic       mac_gmii_tx_rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] mac_gmii_txd,
    output logic       mac_gmii_tx_en,
    output logic       mac_gmii_tx_er,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [3:0] PRE_LEN_C  = 4'(PREAMBLE_LEN);
    localparam logic [3:0] IFG_LAST_C = 4'(IFG_LEN - 1);

    tx_state_t  state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [7:0] txd_q, txd_d;
    logic       tx_en_q, tx_en_d;
    logic       tx_er_q, tx_er_d;
    logic       frame_done_q, frame_done_d;
    logic       underrun_q, underrun_d;

    assign in_ready = (state_q == DATA);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        txd_d        = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // The first preamble byte goes out on the request edge itself,
                // so the counter starts at one.
                if (in_valid) begin
                    txd_d   = PREAMBLE_BYTE;
                    tx_en_d = 1'b1;
                    count_d = 4'd1;
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                tx_en_d = 1'b1;
                if (count_q < PRE_LEN_C) begin
                    txd_d   = PREAMBLE_BYTE;
                    count_d = count_q + 4'd1;
                end else begin
                    txd_d   = SFD_BYTE;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_en_d = 1'b1;
                if (in_valid) begin
                    txd_d = in_data;
                    if (in_last) begin
                        frame_done_d = 1'b1;
                        count_d      = 4'd0;
                        state_d      = IFG;
                    end
                end else begin
                    // Starved mid-frame: poison the frame on the wire and close it.
                    tx_er_d      = 1'b1;
                    underrun_d   = 1'b1;
                    frame_done_d = 1'b1;
                    count_d      = 4'd0;
                    state_d      = IFG;
                end
            end
            IFG: begin
                count_d = count_q + 4'd1;
                if (count_q == IFG_LAST_C) begin
                    count_d = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                count_d = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge mac_gmii_tx_clk or posedge mac_gmii_tx_rst) begin
        if (mac_gmii_tx_rst) begin
            state_q      <= IDLE;
            count_q      <= 4'd0;
            txd_q        <= 8'h00;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            txd_q        <= txd_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign mac_gmii_txd   = txd_q;
    assign mac_gmii_tx_en = tx_en_q;
    assign mac_gmii_tx_er = tx_er_q;
    assign frame_done     = frame_done_q;
    assign underrun       = underrun_q;

endmodule

// File: tb/tb_preamble_sfd_tx.sv
// Bench for preamble_sfd_tx: a frame-level timeline model builds the expected
// per-cycle GMII stream; default and reduced-parameter instances are exercised.
module tb_preamble_sfd_tx;

    localparam int N = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_vld, a_last, b_vld, b_last;
    logic       a_rdy, a_en, a_er, a_done, a_und;
    logic       b_rdy, b_en, b_er, b_done, b_und;
    logic [7:0] a_txd, b_txd;

    always #4 clk = ~clk;

    preamble_sfd_tx dut_a (
        .mac_gmii_tx_clk(clk), .mac_gmii_tx_rst(rst),
        .in_data(a_data), .in_valid(a_vld), .in_last(a_last), .in_ready(a_rdy),
        .mac_gmii_txd(a_txd), .mac_gmii_tx_en(a_en), .mac_gmii_tx_er(a_er),
        .frame_done(a_done), .underrun(a_und)
    );

    preamble_sfd_tx #(.PREAMBLE_LEN(2), .IFG_LEN(3)) dut_b (
        .mac_gmii_tx_clk(clk), .mac_gmii_tx_rst(rst),
        .in_data(b_data), .in_valid(b_vld), .in_last(b_last), .in_ready(b_rdy),
        .mac_gmii_txd(b_txd), .mac_gmii_tx_en(b_en), .mac_gmii_tx_er(b_er),
        .frame_done(b_done), .underrun(b_und)
    );

    // Accepting a byte always puts something on the wire the next cycle.
    assert property (@(posedge clk) disable iff (rst) a_rdy |=> a_en);
    assert property (@(posedge clk) disable iff (rst) b_rdy |=> b_en);

    // Timeline: stimulus applied before edge i, expected outputs after edge i.
    logic       s_vld[N], s_last[N], s_rdy[N];
    logic [7:0] s_data[N];
    logic [7:0] e_txd[N];
    logic       e_en[N], e_er[N], e_done[N], e_und[N];
    int         len;
    int         pre_len, ifg_len;
    logic [7:0] fb[$];

    int checks = 0, failures = 0, cur_step = 0;

    int en_runs[$], idle_runs[$];
    int en_cnt, idle_cnt, rdy_hi, er_hi, und_hi, done_hi;
    logic prev_en, seen_en;
    logic [7:0] done_txd;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, cur_step, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    task automatic push(input logic v, input logic [7:0] d, input logic l, input logic r,
                        input logic [7:0] t, input logic en, input logic er,
                        input logic dn, input logic un);
        if (len < N) begin
            s_vld[len] = v;  s_data[len] = d; s_last[len] = l; s_rdy[len] = r;
            e_txd[len] = t;  e_en[len] = en;  e_er[len] = er;
            e_done[len] = dn; e_und[len] = un;
            len++;
        end
    endtask

    task automatic add_idle(input int n, input logic v, input logic [7:0] d, input logic l);
        for (int i = 0; i < n; i++) push(v, d, l, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One frame from fb: preamble, SFD, payload (or underrun at und_pos), then the IFG.
    // During the IFG the source may already hold the next request (hold).
    task automatic add_frame(input int und_pos, input logic hold,
                             input logic [7:0] hold_d, input logic hold_l);
        int n;
        n = fb.size();
        for (int p = 0; p < pre_len; p++)
            push(1'b1, fb[0], n == 1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, fb[0], n == 1, 1'b0, 8'hD5, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            if (k == und_pos) begin
                push(1'b0, 8'hEE, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
                break;
            end
            push(1'b1, fb[k], k == n - 1, 1'b1, fb[k], 1'b1, 1'b0, k == n - 1, 1'b0);
        end
        add_idle(ifg_len, hold, hold_d, hold_l);
    endtask

    task automatic new_scenario(input int p, input int g);
        len = 0; pre_len = p; ifg_len = g;
        en_runs.delete(); idle_runs.delete();
        en_cnt = 0; idle_cnt = 0; rdy_hi = 0; er_hi = 0; und_hi = 0; done_hi = 0;
        prev_en = 1'b0; seen_en = 1'b0; done_txd = 8'h00;
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
        if (sel == 0) begin
            a_vld = v; a_data = d; a_last = l; b_vld = 1'b0; b_data = 8'h00; b_last = 1'b0;
        end else begin
            b_vld = v; b_data = d; b_last = l; a_vld = 1'b0; a_data = 8'h00; a_last = 1'b0;
        end
    endtask

    task automatic play(input int sel, input int limit);
        logic [7:0] t;
        logic en, er, dn, un, rd, o_rd, o_en;
        for (int i = 0; i < limit; i++) begin
            cur_step = i;
            @(negedge clk);
            drive(sel, s_vld[i], s_data[i], s_last[i]);
            #1;
            rd   = (sel == 0) ? a_rdy : b_rdy;
            o_rd = (sel == 0) ? b_rdy : a_rdy;
            chk("in_ready", rd, s_rdy[i]);
            chk("other_in_ready", o_rd, 0);
            if (rd) rdy_hi++;
            @(posedge clk);
            #1;
            t    = (sel == 0) ? a_txd  : b_txd;
            en   = (sel == 0) ? a_en   : b_en;
            er   = (sel == 0) ? a_er   : b_er;
            dn   = (sel == 0) ? a_done : b_done;
            un   = (sel == 0) ? a_und  : b_und;
            o_en = (sel == 0) ? b_en   : a_en;
            chk("txd", t, e_txd[i]);
            chk("tx_en", en, e_en[i]);
            chk("tx_er", er, e_er[i]);
            chk("frame_done", dn, e_done[i]);
            chk("underrun", un, e_und[i]);
            chk("er_without_en", er && !en, 0);
            chk("other_tx_en", o_en, 0);
            if (en) begin
                if (!prev_en && seen_en) idle_runs.push_back(idle_cnt);
                en_cnt++; idle_cnt = 0; seen_en = 1'b1;
            end else begin
                if (prev_en) begin en_runs.push_back(en_cnt); en_cnt = 0; end
                idle_cnt++;
            end
            prev_en = en;
            if (er) er_hi++;
            if (un) und_hi++;
            if (dn) begin done_hi++; done_txd = t; end
        end
    endtask

    initial begin
        drive(0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_tx_en", a_en, 0);
        chk("rst_txd", a_txd, 0);
        chk("rst_tx_er", a_er, 0);
        chk("rst_done", a_done, 0);
        chk("rst_underrun", a_und, 0);
        chk("rst_in_ready", a_rdy, 0);
        chk("rst_b_tx_en", b_en, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 4-byte frame
        new_scenario(7, 12);
        add_idle(2, 1'b0, 8'h00, 1'b0);
        fb = '{8'h01, 8'h02, 8'h03, 8'h04};
        add_frame(-1, 1'b0, 8'h00, 1'b0);
        play(0, len);
        chk("s1_en_cycles", qget(en_runs, 0), 12);
        chk("s1_done_byte", done_txd, 8'h04);
        chk("s1_trailing_idle", idle_cnt, 12);

        // back-to-back single-byte frames, request held through the IFG
        new_scenario(7, 12);
        fb = '{8'hAA};
        add_frame(-1, 1'b1, 8'hBB, 1'b1);
        fb = '{8'hBB};
        add_frame(-1, 1'b0, 8'h00, 1'b0);
        play(0, len);
        chk("s2_en_run0", qget(en_runs, 0), 9);
        chk("s2_en_run1", qget(en_runs, 1), 9);
        chk("s2_gap", qget(idle_runs, 0), 12);
        chk("s2_ready_cycles", rdy_hi, 2);
        chk("s2_done_count", done_hi, 2);

        // underrun after two bytes, in_last asserted with in_valid low
        new_scenario(7, 12);
        fb = '{8'hB0, 8'hB1, 8'hB2};
        add_frame(2, 1'b0, 8'h00, 1'b0);
        play(0, len);
        chk("s3_en_cycles", qget(en_runs, 0), 11);
        chk("s3_er_cycles", er_hi, 1);
        chk("s3_underrun_count", und_hi, 1);
        chk("s3_done_count", done_hi, 1);

        // random idle gaps before each request
        new_scenario(7, 12);
        for (int f = 0; f < 3; f++) begin
            add_idle($urandom_range(1, 6), 1'b0, 8'h00, 1'b0);
            fb = '{8'($urandom), 8'($urandom)};
            add_frame(-1, 1'b0, 8'h00, 1'b0);
        end
        play(0, len);
        chk("s4_en_run0", qget(en_runs, 0), 10);
        chk("s4_frames", en_runs.size(), 3);

        // reset during the preamble, then a clean restart
        new_scenario(7, 12);
        fb = '{8'hC1};
        add_frame(-1, 1'b0, 8'h00, 1'b0);
        play(0, 3);
        chk("s5_third_preamble", a_txd, 8'h55);
        #2;
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("s5_rst_tx_en", a_en, 0);
        chk("s5_rst_txd", a_txd, 0);
        chk("s5_rst_in_ready", a_rdy, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        new_scenario(7, 12);
        fb = '{8'hC1, 8'hC2};
        add_frame(-1, 1'b0, 8'h00, 1'b0);
        play(0, len);
        chk("s5_restart_en_cycles", qget(en_runs, 0), 10);

        // reduced parameters on the second instance
        new_scenario(2, 3);
        add_idle(1, 1'b0, 8'h00, 1'b0);
        fb = '{8'hD0, 8'hD1};
        add_frame(-1, 1'b1, 8'hE0, 1'b1);
        fb = '{8'hE0};
        add_frame(-1, 1'b0, 8'h00, 1'b0);
        play(1, len);
        chk("s6_en_run0", qget(en_runs, 0), 5);
        chk("s6_en_run1", qget(en_runs, 1), 4);
        chk("s6_gap", qget(idle_runs, 0), 3);
        chk("s6_trailing_idle", idle_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/preamble_sfd_tx.md
Name: preamble_sfd_tx

Overview:
GMII transmit-side framer, the TX counterpart of the receive preamble/SFD checker. Accepts a frame byte stream from the MAC TX path over a valid/ready/last handshake. Prepends PREAMBLE_LEN bytes of 0x55 and one SFD byte 0xD5, then forwards payload bytes onto GMII TXD/TX_EN. Enforces the inter-frame gap (IFG) and flags upstream underrun with TX_ER.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD (valid range 1..15)
IFG_LEN, 12, number of idle cycles (TX_EN=0) after each frame (valid range 1..15)

Ports:
mac_gmii_tx_clk  in  1  GMII transmit clock (125 MHz); the only clock
mac_gmii_tx_rst  in  1  reset, asynchronous, active-high
in_data  in  8  payload byte from the frame builder
in_valid  in  1  in_data is valid; the first asserted in_valid requests frame start
in_last  in  1  marks the final payload byte; qualified by in_valid && in_ready
in_ready  out  1  byte accepted this cycle; combinational, high only in DATA
mac_gmii_txd  out  8  GMII transmit data, registered
mac_gmii_tx_en  out  1  GMII transmit enable, registered
mac_gmii_tx_er  out  1  GMII transmit error, registered
frame_done  out  1  one-cycle pulse, registered: the final byte (in_last or underrun) is on TXD this cycle
underrun  out  1  one-cycle pulse, registered: frame aborted because in_valid dropped in DATA

Behaviour:
- Reset (asynchronous assert; deassertion is synchronised externally):
  - state=IDLE, count=0.
  - txd=0x00, tx_en=0, tx_er=0, frame_done=0, underrun=0.
- All GMII outputs are registered. in_ready = (state==DATA).
- Counter: 4-bit count, shared by PREAMBLE and IFG; it never wraps within the legal parameter range.
- States:
  - IDLE: outputs idle (txd=0, tx_en=0). If in_valid=1, register txd=0x55, tx_en=1, count=1, and go to PREAMBLE. in_data is held upstream and is not consumed.
  - PREAMBLE: if count<PREAMBLE_LEN, emit 0x55 and count++. Otherwise emit 0xD5 and go to DATA. in_ready=0.
  - DATA: in_ready=1.
    - in_valid=1: emit txd=in_data, tx_en=1. If in_last is also set, pulse frame_done, set count=0, and go to IFG.
    - in_valid=0 (underrun): emit txd=0x00, tx_en=1, tx_er=1. Pulse underrun and frame_done, set count=0, and go to IFG.
  - IFG: emit tx_en=0, tx_er=0, txd=0 and count++. When count==IFG_LEN-1, go to IDLE. in_valid is ignored here.
- Latency:
  - A frame request seen in IDLE at edge N puts the first 0x55 on TXD after edge N.
  - The SFD appears after edge N+PREAMBLE_LEN.
  - A payload byte accepted at edge M is on TXD after edge M.
  - Default wire overhead is 8 bytes per frame; minimum spacing is exactly IFG_LEN idle cycles.
- Boundary conditions:
  - A single-byte payload (in_last set on the first DATA byte) is legal.
  - in_valid is already high when IFG ends: IDLE sees it on the following edge, giving exactly IFG_LEN idle cycles and no extra.
  - in_last with in_valid=0 is ignored; it is treated as an underrun.
  - Reset asserted mid-frame: outputs drop to idle immediately. No IFG is enforced after reset.
  - tx_er is only ever high together with tx_en=1.

Decomposition:
- Add a shared package eth_pkg (extend it if it already exists) holding:
  - localparams PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5, also used by preamble_sfd_rx.
  - the state typedef enum {IDLE, PREAMBLE, SFD_UNUSED_RESERVED, DATA, IFG} is not needed; use a 3-bit enum tx_state_t {IDLE, PREAMBLE, DATA, IFG}.
- No sub-module; a single FSM with a counter is natural.

Test Plan:
- Reset, then send a 4-byte frame 0x01,0x02,0x03,0x04 (last on 0x04) with in_valid held high -> TXD shows 7×0x55, 0xD5, 01,02,03,04 with tx_en=1 for exactly 12 cycles; frame_done pulses with 0x04; then 12 cycles of tx_en=0.
- Two back-to-back 1-byte frames (0xAA, 0xBB) with in_valid held -> each frame is 9 tx_en cycles; exactly 12 idle cycles between them; in_ready high only on the 0xAA and 0xBB cycles.
- Underrun: 3-byte frame with in_valid dropped after byte 2 -> TXD 55×7, D5, b0, b1, then one cycle tx_en=1/tx_er=1/txd=00; underrun and frame_done pulse; then the IFG.
- Reset asserted during the preamble (after the 3rd 0x55) -> the next cycle shows tx_en=0, txd=0; after release with in_valid=1, a full 7-byte preamble restarts.
- Parameter override PREAMBLE_LEN=2, IFG_LEN=3, 2-byte frame -> 55,55,D5,d0,d1 then 3 idle cycles; an assertion checks in_ready is never high outside DATA.
- Random valid gaps before frame start (in_valid low in IDLE) -> no tx_en activity until in_valid rises; first 0x55 appears one edge after it.
